// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the four-channel round-robin grant path.
package arb_pkg;
  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_arb4_sel_pick4.sv
// Combinational rotate-and-priority picker: first set req bit scanning ptr, ptr+1, ... mod 4.
// Zero latency; idx is don't-care (reports ptr) when no request is present.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              any,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the far end so the candidate closest to ptr overwrites the others.
  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter feeding a 2-to-4 enable decoder: 1-cycle grant latency, registered outputs,
// one forced dead cycle between grants, optional MAX_HOLD revocation; arb_en=0 only blocks new grants.
module rr_arb4_sel
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  input  logic              arb_en,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT_C = '1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              rel_user, rel_hold, rel_any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // A timeout pulse is reported only when the hold limit is the sole reason for release.
  assign rel_user = done | ~req[gnt_idx_q];
  assign rel_hold = (MAX_HOLD != 0) && (hold_q == HOLD_MAX_C);
  assign rel_any  = rel_user | rel_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_en && pick_any) state_d = GRANT;
      GRANT:   if (rel_any) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    hold_d      = hold_q;
    gnt_valid_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && pick_any) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_d      = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (rel_any) begin
          ptr_d     = gnt_idx_q + IDX_W'(1);
          hold_d    = '0;
          timeout_d = rel_hold & ~rel_user;
        end else begin
          gnt_valid_d = 1'b1;
          if (hold_q != HOLD_SAT_C) hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Bench for rr_arb4_sel (MAX_HOLD=8): per-cycle reference model feeds an expectation queue,
// plus scenario-level checks and an exhaustive sweep of the picker.
module tb_rr_arb4_sel;

  logic       clk = 1'b0;
  logic       rst, done, arb_en;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_valid, timeout;

  logic [3:0] pk_req;
  logic [1:0] pk_ptr, pk_idx;
  logic       pk_any;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp;

  // Reference model state: 0=idle, 1=grant, 2=gap
  int m_st, m_ptr, m_idx, m_hold;
  bit m_valid, m_to;
  localparam int MAXH = 8;

  always #5 clk = ~clk;

  rr_arb4_sel #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .arb_en(arb_en),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_pick4 u_pick (.req(pk_req), .ptr(pk_ptr), .any(pk_any), .idx(pk_idx));

  task automatic model_step(input logic r, input logic [3:0] rq, input logic d, input logic e);
    if (r) begin
      m_st = 0; m_ptr = 0; m_hold = 0; m_idx = 0; m_valid = 0; m_to = 0;
    end else begin
      m_to = 0;
      case (m_st)
        0: begin
          int w;
          w = m_ptr;
          if (e && rq != 4'b0000) begin
            while (!rq[w]) w = (w + 1) % 4;
            m_idx = w; m_valid = 1; m_hold = 1; m_st = 1;
          end else begin
            m_valid = 0;
          end
        end
        1: begin
          bit ru, rh;
          ru = d || !rq[m_idx];
          rh = (m_hold == MAXH);
          if (ru || rh) begin
            m_valid = 0; m_ptr = (m_idx + 1) % 4; m_hold = 0; m_st = 2;
            m_to = rh && !ru;
          end else begin
            m_hold = m_hold + 1;
          end
        end
        default: begin
          m_valid = 0; m_st = 0;
        end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic d, input logic e);
    @(negedge clk);
    rst = r; req = rq; done = d; arb_en = e;
    model_step(r, rq, d, e);
    exp_q.push_back({m_valid, m_idx[1:0], m_to});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 1:    step(1'b1, 4'b1111, 1'b1, 1'b1);
        2:       step(1'b0, 4'b1111, 1'b0, 1'b1);
        3:       step(1'b0, 4'b1111, 1'b1, 1'b1);
        default: step(1'b0, 4'b0000, 1'b0, 1'b1);
      endcase
      exp = exp_q.pop_front(); n_vec++;
      if ({gnt_valid, gnt_idx, timeout} !== exp) begin
        n_bad++;
        $display("FAIL reset c%0d: got valid/idx/to=%b want %b", c, {gnt_valid, gnt_idx, timeout}, exp);
      end
      if (c == 2) begin
        n_vec++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
          n_bad++;
          $display("FAIL reset_first_grant: got valid=%b idx=%0d want valid=1 idx=0", gnt_valid, gnt_idx);
        end
      end
    end
  endtask

  task automatic test_single;
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b0100, (c == 4), 1'b1);
      exp = exp_q.pop_front(); n_vec++;
      if ({gnt_valid, gnt_idx, timeout} !== exp) begin
        n_bad++;
        $display("FAIL single c%0d: got valid/idx/to=%b want %b", c, {gnt_valid, gnt_idx, timeout}, exp);
      end
      if (c == 6) begin
        n_vec++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin
          n_bad++;
          $display("FAIL single_regrant: got valid=%b idx=%0d want valid=1 idx=2", gnt_valid, gnt_idx);
        end
      end
    end
  endtask

  task automatic test_rotation;
    int order[5] = '{0, 1, 2, 3, 0};
    int ng, low;
    bit prev;
    ng = 0; low = 0; prev = 0;
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b1111, (c % 4 == 2), 1'b1);
      exp = exp_q.pop_front(); n_vec++;
      if ({gnt_valid, gnt_idx, timeout} !== exp) begin
        n_bad++;
        $display("FAIL rotation c%0d: got valid/idx/to=%b want %b", c, {gnt_valid, gnt_idx, timeout}, exp);
      end
      if (gnt_valid && !prev) begin
        if (ng < 5) begin
          n_vec++;
          if (gnt_idx !== 2'(order[ng])) begin
            n_bad++;
            $display("FAIL rotation_order g%0d: got idx=%0d want %0d", ng, gnt_idx, order[ng]);
          end
        end
        if (ng > 0) begin
          n_vec++;
          if (low != 2) begin
            n_bad++;
            $display("FAIL rotation_gap g%0d: got %0d low cycles want 2", ng, low);
          end
        end
        ng++; low = 0;
      end else if (!gnt_valid && ng > 0) begin
        low++;
      end
      prev = gnt_valid;
    end
  endtask

  task automatic test_timeout;
    int run, to_seen;
    run = 0;
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int c = 0; c < 22; c++) begin
      step(1'b0, 4'b0010, 1'b0, 1'b1);
      exp = exp_q.pop_front(); n_vec++;
      if ({gnt_valid, gnt_idx, timeout} !== exp) begin
        n_bad++;
        $display("FAIL timeout c%0d: got valid/idx/to=%b want %b", c, {gnt_valid, gnt_idx, timeout}, exp);
      end
      if (gnt_valid) run++;
      else begin
        if (run > 0) begin
          n_vec++;
          if (run != MAXH || timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_run c%0d: got run=%0d to=%b want run=8 to=1", c, run, timeout);
          end
        end
        run = 0;
      end
    end
    to_seen = 0;
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b0010, (c == 8), 1'b1);
      exp = exp_q.pop_front(); n_vec++;
      if ({gnt_valid, gnt_idx, timeout} !== exp) begin
        n_bad++;
        $display("FAIL timeout_done c%0d: got valid/idx/to=%b want %b", c, {gnt_valid, gnt_idx, timeout}, exp);
      end
      if (timeout === 1'b1) to_seen++;
    end
    n_vec++;
    if (to_seen != 0) begin
      n_bad++;
      $display("FAIL timeout_suppressed: got %0d pulses want 0", to_seen);
    end
  endtask

  task automatic test_enable_drop;
    // {rst, req[3:0], done, arb_en}
    logic [6:0] tv [14] = '{
      7'b0_1111_0_0, 7'b0_1111_0_0, 7'b0_1111_0_0, 7'b0_1111_0_1,
      7'b0_1111_0_0, 7'b0_1111_0_0, 7'b0_1111_0_0, 7'b0_1111_0_0,
      7'b0_1111_1_0, 7'b0_1111_0_0, 7'b0_1111_0_1, 7'b0_1101_0_1,
      7'b0_1101_0_1, 7'b0_1101_0_1};
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int c = 0; c < 14; c++) begin
      step(tv[c][6], tv[c][5:2], tv[c][1], tv[c][0]);
      exp = exp_q.pop_front(); n_vec++;
      if ({gnt_valid, gnt_idx, timeout} !== exp) begin
        n_bad++;
        $display("FAIL enable_drop c%0d: got valid/idx/to=%b want %b", c, {gnt_valid, gnt_idx, timeout}, exp);
      end
      if (c == 7 || c == 13) begin
        n_vec++;
        if (gnt_valid !== 1'b1 || gnt_idx !== ((c == 7) ? 2'd0 : 2'd2)) begin
          n_bad++;
          $display("FAIL enable_drop_owner c%0d: got valid=%b idx=%0d", c, gnt_valid, gnt_idx);
        end
      end
    end
  endtask

  task automatic test_rst_mid;
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int c = 0; c < 6; c++) begin
      if (c < 3)       step(1'b0, 4'b1000, 1'b0, 1'b1);
      else if (c == 3) step(1'b1, 4'b1000, 1'b0, 1'b1);
      else             step(1'b0, 4'b1001, 1'b0, 1'b1);
      exp = exp_q.pop_front(); n_vec++;
      if ({gnt_valid, gnt_idx, timeout} !== exp) begin
        n_bad++;
        $display("FAIL rst_mid c%0d: got valid/idx/to=%b want %b", c, {gnt_valid, gnt_idx, timeout}, exp);
      end
      if (c == 4) begin
        n_vec++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
          n_bad++;
          $display("FAIL rst_mid_first: got valid=%b idx=%0d want valid=1 idx=0", gnt_valid, gnt_idx);
        end
      end
    end
  endtask

  task automatic test_pick;
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 16; r++) begin
        int w;
        logic [3:0] rv;
        rv = 4'(r);
        pk_req = rv; pk_ptr = 2'(p);
        #1;
        w = p;
        if (rv != 4'b0000) while (!rv[w]) w = (w + 1) % 4;
        n_vec++;
        if (pk_any !== (rv != 4'b0000) || (rv != 4'b0000 && pk_idx !== 2'(w))) begin
          n_bad++;
          $display("FAIL pick ptr=%0d req=%b: got any=%b idx=%0d want any=%b idx=%0d",
                   p, rv, pk_any, pk_idx, (rv != 4'b0000), w);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0; arb_en = 1'b0;
    pk_req = 4'b0000; pk_ptr = 2'b00;
    test_reset;
    test_single;
    test_rotation;
    test_timeout;
    test_enable_drop;
    test_rst_mid;
    test_pick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
